data_capture_initial_fifos: RTL and testbench
=============================================

# data_capture_initial_fifos

Triggered burst-capture buffer at the front of the ADC data path. On a rising edge of `FastTrigger`, while capture is enabled, it writes a fixed-length burst of consecutive 32-bit ADC words into an on-chip FIFO. It then flags the burst as ready and lets downstream logic drain it word-by-word with a read-enable/valid handshake. It re-arms automatically once the burst has been fully read.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of captured word (4 ADC byte lanes).
- `CAPTURE_DEPTH`, 128, words per burst; power of two, ≥ 4.
- `ADDR_WIDTH`, log2(`CAPTURE_DEPTH`), FIFO pointer width (derived).

Ports:
- `DataClk`  in  1  sole clock. One clock; reset is asynchronous and active-high. Capture and read sides are both synchronous to `DataClk`.
- `Reset`  in  1  asynchronous, active-high reset.
- `DataIn`  in  32  ADC word, sampled on every `DataClk` rising edge.
- `FastTrigger`  in  1  trigger; its rising edge starts a burst.
- `EnableDataCapture`  in  1  arms the block; triggers are ignored while low.
- `RdEn`  in  1  pop request from downstream.
- `s1DataOut`  out  32  word popped from the FIFO (registered).
- `DataReady`  out  1  a complete burst is held and not yet fully drained.
- `DataValid`  out  1  `s1DataOut` carries a freshly popped word this cycle.

## Operation
- Trigger detect: `trig = FastTrigger & ~FastTrigger_q`. `FastTrigger_q` is a register with reset value 0. A level held high does not retrigger.
- The FSM has three states: IDLE, CAPTURE and READY.
- IDLE:
  - FIFO is empty and `DataReady` = 0.
  - `trig` & `EnableDataCapture` → CAPTURE, with the write counter cleared.
- CAPTURE:
  - Writes `DataIn` on each edge.
  - After exactly `CAPTURE_DEPTH` writes → READY.
  - Further triggers are ignored.
  - Deasserting `EnableDataCapture` does not abort a burst in progress.
- READY:
  - `DataReady` = 1.
  - `RdEn` pops one word per cycle.
  - When the last word is popped → IDLE, with `DataReady` = 0 from the next cycle and the block re-armed.
  - Triggers are ignored.
- Read handshake:
  - A pop happens when `RdEn`=1 & state=READY & FIFO not empty.
  - On a pop, `s1DataOut` ← head word and `DataValid` ← 1.
  - Otherwise `DataValid` ← 0 and `s1DataOut` holds its last value.
  - `RdEn` outside READY is ignored (no pop, `DataValid` = 0).
- FIFO: single-clock, `CAPTURE_DEPTH` × `DATA_WIDTH`, with pointers of `ADDR_WIDTH`+1 bits so full and empty can be told apart. Write is never attempted when full; read is never attempted when empty.
- Words are stored and returned unmodified, in capture order.

## Timing
- Reset values:
  - FSM = IDLE, pointers = 0, counters = 0, `FastTrigger_q` = 0.
  - `s1DataOut` = 0, `DataReady` = 0, `DataValid` = 0.
- Reset asserted mid-burst or mid-drain flushes the FIFO and returns the block to IDLE immediately (asynchronous).
- Capture timing: if `trig` is sampled at edge k, `DataIn` is written at edges k+1 … k+`CAPTURE_DEPTH`. `DataIn` present at edge k itself is not stored.
- `DataReady` rises one cycle after the final write, i.e. it is visible after edge k+`CAPTURE_DEPTH`+1.
- Read latency: when `RdEn` is sampled at edge n, `s1DataOut`/`DataValid` are valid after edge n, for one cycle per pop.
- Continuous `RdEn` drains one word per cycle; a burst takes `CAPTURE_DEPTH` cycles.
- On the edge that pops the last word, the FSM moves to IDLE. A trigger can be accepted from the following edge onward.

## Structure
- Shared package holds:
  - the FSM state enum (`IDLE`, `CAPTURE`, `READY`);
  - default `DATA_WIDTH` and `CAPTURE_DEPTH` constants.
- Sub-module `sync_fifo`, parameterized by width and depth, exposes wr_en, rd_en, din, dout, full, empty and reset. It has one clock and an asynchronous reset.
- The top level contains the trigger edge detect, the FSM, the write counter and the output registers.

## Test plan
- Reset: hold `Reset` for 100 ns, then check all outputs = 0. Pulse `RdEn` while IDLE → `DataValid` stays 0.
- Basic burst:
  - Stimulus: `DataIn` = {b,b,b,b}, where byte b increments every cycle and clears to 0 on the cycle `FastTrigger` is high. Apply a one-cycle trigger pulse.
  - Required response: `DataReady` rises `CAPTURE_DEPTH`+1 cycles after the trigger edge.
  - Holding `RdEn` high returns 0x00000000, 0x01010101, …, 0x7F7F7F7F on consecutive cycles, each with `DataValid` = 1.
- Drain end: after the 128th pop, `DataReady` = 0 and the next `DataValid` = 0. A new trigger then captures a fresh burst.
- Gating:
  - Trigger with `EnableDataCapture` = 0 → no capture and `DataReady` stays 0.
  - Trigger during CAPTURE or READY → ignored; data is unchanged.
  - `FastTrigger` held high → only one burst.
- Throttled read: toggle `RdEn` 1/0 → a pop occurs only on cycles where `RdEn` is high, and order is preserved.
- Reset mid-capture (e.g. after 40 writes) → all outputs 0 and state IDLE. A subsequent trigger captures a full, correct burst.

Source files
------------

// File: rtl/data_capture_initial_fifos_pkg.sv
// Shared types and defaults for the triggered burst-capture buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package data_capture_initial_fifos_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_CAPTURE_DEPTH = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

endpackage

// File: rtl/data_capture_initial_fifos_if.sv
// Bundles the ADC capture inputs and the drain handshake of the capture buffer.
// Latency: none (wiring only).
// Backpressure: downstream paces the drain with RdEn; capture side has none.
interface data_capture_initial_fifos_if
  import data_capture_initial_fifos_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  FastTrigger;
  logic                  EnableDataCapture;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] s1DataOut;
  logic                  DataReady;
  logic                  DataValid;

  // Source of ADC data/trigger and consumer of the burst.
  modport master (
    output DataIn, FastTrigger, EnableDataCapture, RdEn,
    input  s1DataOut, DataReady, DataValid
  );

  // The capture buffer itself.
  modport slave (
    input  DataIn, FastTrigger, EnableDataCapture, RdEn,
    output s1DataOut, DataReady, DataValid
  );
endinterface

// File: rtl/data_capture_initial_fifos_sync_fifo.sv
// Single-clock FIFO with extra pointer wrap bit to separate full from empty.
// Latency: written word is visible at dout one cycle after the write edge; dout is the head, combinational.
// Backpressure: writes while full and reads while empty are dropped internally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer advance; reset flushes the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/data_capture_initial_fifos.sv
// Captures a fixed-length ADC burst on a trigger rising edge and lets downstream drain it.
// Latency: write at edges k+1..k+DEPTH after trigger edge k; DataReady after k+DEPTH+1; pop data one cycle after RdEn.
// Backpressure: RdEn paces the drain one word per cycle; no new capture until the burst is fully read.
module data_capture_initial_fifos
  import data_capture_initial_fifos_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CAPTURE_DEPTH = DEF_CAPTURE_DEPTH,
  parameter int ADDR_WIDTH    = $clog2(CAPTURE_DEPTH)
) (
  input logic                   DataClk,
  input logic                   Reset,
  data_capture_initial_fifos_if.slave bus
);
  state_t                  state;
  state_t                  state_nxt;
  logic                    FastTrigger_q;
  logic                    trig;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    cnt_last;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_dout;

  assign trig     = bus.FastTrigger & ~FastTrigger_q;
  assign cnt_last = (cnt == ADDR_WIDTH'(CAPTURE_DEPTH - 1));
  assign fifo_wr  = (state == CAPTURE) & ~fifo_full;
  assign fifo_rd  = bus.RdEn & (state == READY) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (CAPTURE_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_fifo (
    .clk   (DataClk),
    .reset (Reset),
    .wr_en (fifo_wr),
    .rd_en (fifo_rd),
    .din   (bus.DataIn),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Trigger history for rising-edge detection.
  always_ff @(posedge DataClk or posedge Reset) begin
    if (Reset) FastTrigger_q <= 1'b0;
    else       FastTrigger_q <= bus.FastTrigger;
  end

  // FSM state register.
  always_ff @(posedge DataClk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: arm on trigger, leave capture after the last write, re-arm after the last pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig && bus.EnableDataCapture) state_nxt = CAPTURE;
      CAPTURE: if (fifo_wr && cnt_last)           state_nxt = READY;
      READY:   if (fifo_rd && cnt_last)           state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // One counter serves both phases: writes in CAPTURE, pops in READY; cleared on every state change.
  always_ff @(posedge DataClk or posedge Reset) begin
    if (Reset)                      cnt <= '0;
    else if (state != state_nxt)    cnt <= '0;
    else if (fifo_wr || fifo_rd)    cnt <= cnt + ADDR_WIDTH'(1);
  end

  // Output registers: DataReady lags entry to READY by a cycle and drops on the final pop edge.
  always_ff @(posedge DataClk or posedge Reset) begin
    if (Reset) begin
      bus.s1DataOut <= '0;
      bus.DataValid <= 1'b0;
      bus.DataReady <= 1'b0;
    end else begin
      bus.DataValid <= fifo_rd;
      if (fifo_rd) bus.s1DataOut <= fifo_dout;
      bus.DataReady <= (state == READY) && (state_nxt == READY);
    end
  end
endmodule

// File: tb/tb_data_capture_initial_fifos.sv
// Directed bench for the burst-capture buffer: reset, burst timing, drain order, gating, throttling, mid-burst reset.
module tb_data_capture_initial_fifos;
  import data_capture_initial_fifos_pkg::*;

  localparam int DEPTH = 128;

  logic DataClk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] b = 8'd0;
  logic clr_b = 1'b0;

  data_capture_initial_fifos_if bus ();

  data_capture_initial_fifos dut (
    .DataClk (DataClk),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #5 DataClk = ~DataClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then update the ADC byte pattern (cleared after an accepted trigger edge).
  task automatic tick();
    @(posedge DataClk);
    #1;
    if (clr_b) b = 8'd0;
    else       b = b + 8'd1;
    clr_b = 1'b0;
    bus.DataIn = {4{b}};
  endtask

  // One-cycle trigger pulse whose edge restarts the byte pattern.
  task automatic pulse_trigger();
    bus.FastTrigger = 1'b1;
    clr_b = 1'b1;
    tick();
    bus.FastTrigger = 1'b0;
  endtask

  // Count edges after the trigger edge until DataReady is seen; n0 edges already elapsed.
  task automatic wait_ready(input string tag, input int n0);
    int n;
    n = n0;
    while (bus.DataReady !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, n, DEPTH + 1);
  endtask

  // Drain a full burst; throttle alternates RdEn high/low.
  task automatic drain(input string tag, input bit throttle);
    int j;
    int n;
    logic [7:0] jb;
    j = 0;
    n = 0;
    while (j < DEPTH && n < 600) begin
      bus.RdEn = !throttle || (n % 2 == 0);
      tick();
      n++;
      if (bus.RdEn) begin
        jb = j[7:0];
        chk({tag, "_valid"}, bus.DataValid, 1);
        chk({tag, "_data"}, bus.s1DataOut, {4{jb}});
        j++;
        if (j < DEPTH) chk({tag, "_ready_hi"}, bus.DataReady, 1);
      end else begin
        jb = 8'(j - 1);
        chk({tag, "_idle_valid"}, bus.DataValid, 0);
        chk({tag, "_hold"}, bus.s1DataOut, {4{jb}});
      end
    end
    chk({tag, "_count"}, j, DEPTH);
    chk({tag, "_ready_lo"}, bus.DataReady, 0);
    bus.RdEn = 1'b1;
    tick();
    chk({tag, "_after_valid"}, bus.DataValid, 0);
    bus.RdEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.DataIn = '0;
    bus.FastTrigger = 1'b0;
    bus.EnableDataCapture = 1'b0;
    bus.RdEn = 1'b0;
    #100;
    chk("rst_out", bus.s1DataOut, 0);
    chk("rst_ready", bus.DataReady, 0);
    chk("rst_valid", bus.DataValid, 0);
    Reset = 1'b0;
    tick();

    // RdEn while idle must not pop
    bus.RdEn = 1'b1;
    tick();
    chk("idle_rd_valid", bus.DataValid, 0);
    bus.RdEn = 1'b0;
    tick();
    chk("idle_rd_valid2", bus.DataValid, 0);
    chk("idle_rd_out", bus.s1DataOut, 0);

    // Burst A: extra trigger mid-capture with enable dropped, then a trigger while READY
    bus.EnableDataCapture = 1'b1;
    pulse_trigger();
    repeat (40) tick();
    bus.FastTrigger = 1'b1;
    tick();
    bus.FastTrigger = 1'b0;
    bus.EnableDataCapture = 1'b0;
    wait_ready("lat_a", 41);
    bus.EnableDataCapture = 1'b1;
    bus.FastTrigger = 1'b1;
    tick();
    bus.FastTrigger = 1'b0;
    tick();
    chk("ready_trig_ignored", bus.DataReady, 1);
    drain("a", 1'b0);

    // Burst B: fresh capture after re-arm, throttled drain
    pulse_trigger();
    wait_ready("lat_b", 0);
    drain("b", 1'b1);

    // Gating: trigger with capture disabled
    bus.EnableDataCapture = 1'b0;
    bus.FastTrigger = 1'b1;
    tick();
    bus.FastTrigger = 1'b0;
    repeat (140) tick();
    chk("gated_ready", bus.DataReady, 0);

    // Held trigger yields exactly one burst
    bus.EnableDataCapture = 1'b1;
    bus.FastTrigger = 1'b1;
    clr_b = 1'b1;
    tick();
    wait_ready("lat_held", 0);
    drain("held", 1'b0);
    repeat (140) tick();
    chk("held_no_retrigger", bus.DataReady, 0);
    bus.FastTrigger = 1'b0;
    tick();

    // Reset after 40 writes
    pulse_trigger();
    repeat (40) tick();
    Reset = 1'b1;
    #1;
    chk("midrst_out", bus.s1DataOut, 0);
    chk("midrst_ready", bus.DataReady, 0);
    chk("midrst_valid", bus.DataValid, 0);
    tick();
    tick();
    Reset = 1'b0;
    repeat (140) tick();
    chk("midrst_idle_ready", bus.DataReady, 0);
    bus.RdEn = 1'b1;
    tick();
    chk("midrst_idle_valid", bus.DataValid, 0);
    bus.RdEn = 1'b0;
    pulse_trigger();
    wait_ready("lat_post_rst", 0);
    drain("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
